// File: rtl/imem_loader_ctrl_if.sv
// rtl/imem_loader_ctrl_if.sv - fetch, byte-load and memory-port bundle for imem_loader_ctrl
interface imem_loader_ctrl_if #(
  parameter int ADDR_W = 10
);
  logic              fetch_req;
  logic [31:0]       fetch_addr;
  logic              fetch_valid;
  logic [31:0]       fetch_instr;
  logic              stall;
  logic              load_start;
  logic              load_valid;
  logic [7:0]        load_byte;
  logic              load_last;
  logic              load_ready;
  logic [ADDR_W-1:0] mem_raddr;
  logic [31:0]       mem_rdata;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [31:0]       mem_wdata;
  logic              load_done;
  logic [ADDR_W:0]   load_count;
  logic              overflow;

  // Controller side
  modport master (
    input  fetch_req, fetch_addr, load_start, load_valid, load_byte, load_last, mem_rdata,
    output fetch_valid, fetch_instr, stall, load_ready, mem_raddr, mem_we, mem_waddr,
           mem_wdata, load_done, load_count, overflow
  );

  // Core / byte source / memory side
  modport slave (
    output fetch_req, fetch_addr, load_start, load_valid, load_byte, load_last, mem_rdata,
    input  fetch_valid, fetch_instr, stall, load_ready, mem_raddr, mem_we, mem_waddr,
           mem_wdata, load_done, load_count, overflow
  );
endinterface

// File: rtl/imem_loader_ctrl.sv
// rtl/imem_loader_ctrl.sv - instruction memory loader/fetch arbiter; IMEM_CLEAR_EN adds a zero-fill pass before loading
module imem_loader_ctrl #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input logic             clk,
  input logic             rst_n,
  imem_loader_ctrl_if.master bus
);

  localparam logic [1:0] ST_RUN   = 2'd0;
`ifdef IMEM_CLEAR_EN
  localparam logic [1:0] ST_CLEAR = 2'd1;
`endif
  localparam logic [1:0] ST_LOAD  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [31:0]     NOP     = 32'h0000_0013;
  localparam logic [ADDR_W:0] FULL    = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0] CNT_ONE = 1;

  logic [1:0]      state;
  logic [1:0]      lane;
  logic [31:0]     word_buf;
  logic [31:0]     pack_word;
  logic            last_pend;
  logic            in_run;
  logic            fetch_go;
  logic            accept;
  logic            word_full;
`ifdef IMEM_CLEAR_EN
  logic [ADDR_W:0] clr_idx;
`endif

  assign in_run         = (state == ST_RUN);
  // load_start takes priority over a fetch presented in the same cycle
  assign fetch_go       = in_run && bus.fetch_req && !bus.load_start;
  // once the final byte is taken, stop accepting while its word is written
  assign bus.load_ready = (state == ST_LOAD) && !last_pend;
  assign accept         = bus.load_valid && bus.load_ready;
  assign word_full      = accept && ((lane == 2'd3) || bus.load_last);
  assign bus.stall      = bus.fetch_req && (!in_run || bus.load_start);
  assign bus.mem_raddr  = in_run ? bus.fetch_addr[ADDR_W-1:0] : '0;
  assign bus.load_done  = (state == ST_DONE);

  // Merge the incoming byte into its big-endian lane; a new word starts from zero
  always_comb begin
    pack_word = (lane == 2'd0) ? 32'h0 : word_buf;
    case (lane)
      2'd0:    pack_word[31:24] = bus.load_byte;
      2'd1:    pack_word[23:16] = bus.load_byte;
      2'd2:    pack_word[15:8]  = bus.load_byte;
      default: pack_word[7:0]   = bus.load_byte;
    endcase
  end

  // Fetch response register: one-cycle latency, out-of-range indices return NOP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.fetch_valid <= 1'b0;
      bus.fetch_instr <= 32'h0;
    end else begin
      bus.fetch_valid <= fetch_go;
      if (fetch_go)
        bus.fetch_instr <= (|bus.fetch_addr[31:ADDR_W]) ? NOP : bus.mem_rdata;
    end
  end

  // Load sequencer: byte packing, word writes, capacity tracking and state flow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_RUN;
      lane           <= 2'd0;
      word_buf       <= 32'h0;
      last_pend      <= 1'b0;
      bus.mem_we     <= 1'b0;
      bus.mem_waddr  <= '0;
      bus.mem_wdata  <= 32'h0;
      bus.load_count <= '0;
      bus.overflow   <= 1'b0;
`ifdef IMEM_CLEAR_EN
      clr_idx        <= '0;
`endif
    end else begin
      bus.mem_we <= 1'b0;
      case (state)
        ST_RUN: begin
          if (bus.load_start) begin
            lane           <= 2'd0;
            word_buf       <= 32'h0;
            last_pend      <= 1'b0;
            bus.load_count <= '0;
            bus.overflow   <= 1'b0;
`ifdef IMEM_CLEAR_EN
            clr_idx        <= '0;
            state          <= ST_CLEAR;
`else
            state          <= ST_LOAD;
`endif
          end
        end
`ifdef IMEM_CLEAR_EN
        ST_CLEAR: begin
          if (clr_idx == FULL) begin
            state <= ST_LOAD;
          end else begin
            bus.mem_we    <= 1'b1;
            bus.mem_waddr <= clr_idx[ADDR_W-1:0];
            bus.mem_wdata <= 32'h0;
            clr_idx       <= clr_idx + CNT_ONE;
          end
        end
`endif
        ST_LOAD: begin
          if (last_pend) begin
            state <= ST_DONE;
          end else if (accept) begin
            word_buf <= pack_word;
            lane     <= word_full ? 2'd0 : lane + 2'd1;
            if (bus.load_last)
              last_pend <= 1'b1;
            // a full image drops further bytes but still honours load_last
            if (bus.load_count == FULL) begin
              bus.overflow <= 1'b1;
            end else if (word_full) begin
              bus.mem_we     <= 1'b1;
              bus.mem_waddr  <= bus.load_count[ADDR_W-1:0];
              bus.mem_wdata  <= pack_word;
              bus.load_count <= bus.load_count + CNT_ONE;
            end
          end
        end
        ST_DONE: state <= ST_RUN;
        default: state <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader_ctrl.sv
// tb/tb_imem_loader_ctrl.sv - randomized self-checking bench for imem_loader_ctrl
module tb_imem_loader_ctrl;
  localparam int DEPTH = 1024;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  imem_loader_ctrl_if #(.ADDR_W(10)) bus();

  imem_loader_ctrl #(.DEPTH(DEPTH), .ADDR_W(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [31:0] mem     [DEPTH];
  logic [31:0] ref_mem [DEPTH];
  logic [7:0]  bq [$];
  logic [31:0] exp_wa [$];
  logic [31:0] exp_wd [$];
  int          widx = 0;
  int          n_checks = 0;
  int          n_pass = 0;

  assign bus.mem_rdata = mem[bus.mem_raddr];
  always @(posedge clk) if (bus.mem_we) mem[bus.mem_waddr] <= bus.mem_wdata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // every memory write must match the next entry of the expected write list
  always @(negedge clk) begin
    if (rst_n && bus.mem_we) begin
      if (widx < exp_wa.size()) begin
        check("waddr", 32'(bus.mem_waddr), exp_wa[widx]);
        check("wdata", bus.mem_wdata, exp_wd[widx]);
      end else begin
        check("extra_write", 32'(bus.mem_waddr), 32'hFFFF_FFFF);
      end
      widx++;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: time limit reached, checks %0d", n_checks);
    $fatal(1);
  end

  function automatic logic [31:0] ref_fetch(input logic [31:0] a);
    return (a >= DEPTH) ? 32'h0000_0013 : ref_mem[a[9:0]];
  endfunction

  task automatic check_reset_vals();
    check("rst_fetch_valid", bus.fetch_valid, 0);
    check("rst_fetch_instr", bus.fetch_instr, 0);
    check("rst_stall", bus.stall, 0);
    check("rst_load_ready", bus.load_ready, 0);
    check("rst_mem_we", bus.mem_we, 0);
    check("rst_mem_waddr", 32'(bus.mem_waddr), 0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    check("rst_mem_raddr", 32'(bus.mem_raddr), 0);
    check("rst_load_done", bus.load_done, 0);
    check("rst_load_count", 32'(bus.load_count), 0);
    check("rst_overflow", bus.overflow, 0);
  endtask

  task automatic push_clear();
`ifdef IMEM_CLEAR_EN
    for (int i = 0; i < DEPTH; i++) begin
      exp_wa.push_back(i);
      exp_wd.push_back(32'h0);
    end
`endif
  endtask

  task automatic apply_clear();
`ifdef IMEM_CLEAR_EN
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
`endif
  endtask

  task automatic do_fetch(input logic [31:0] a, input logic [31:0] e);
    bus.fetch_req = 1'b1;
    bus.fetch_addr = a;
    @(negedge clk);
    check("stall_fetch", bus.stall, 0);
    @(posedge clk); #1;
    check("fvalid_fetch", bus.fetch_valid, 1);
    check("finstr_fetch", bus.fetch_instr, e);
    bus.fetch_req = 1'b0;
    bus.fetch_addr = 32'h0;
  endtask

  task automatic fetch_burst(input int n);
    logic [31:0] pend = 32'h0;
    logic [31:0] a;
    bit has = 1'b0;
    for (int k = 0; k <= n; k++) begin
      if (has) begin
        check("fvalid_burst", bus.fetch_valid, 1);
        check("finstr_burst", bus.fetch_instr, pend);
      end
      if (k < n) begin
        if ($urandom_range(0, 3) == 0) a = $urandom | 32'h0000_0400;
        else a = $urandom_range(0, DEPTH - 1);
        bus.fetch_req = 1'b1;
        bus.fetch_addr = a;
        pend = ref_fetch(a);
        has = 1'b1;
      end else begin
        bus.fetch_req = 1'b0;
        bus.fetch_addr = 32'h0;
        has = 1'b0;
      end
      @(negedge clk);
      if (k < n) check("stall_burst", bus.stall, 0);
      @(posedge clk); #1;
    end
  endtask

  // a fetch one cycle ahead of load_start is still answered; the colliding one is not
  task automatic start_load();
    logic [31:0] a;
    logic [31:0] e;
    a = $urandom_range(0, DEPTH - 1);
    e = ref_fetch(a);
    bus.fetch_req = 1'b1;
    bus.fetch_addr = a;
    @(posedge clk); #1;
    bus.load_start = 1'b1;
    bus.fetch_addr = $urandom_range(0, DEPTH - 1);
    @(negedge clk);
    check("stall_start", bus.stall, 1);
    check("fvalid_pre_start", bus.fetch_valid, 1);
    check("finstr_pre_start", bus.fetch_instr, e);
    @(posedge clk); #1;
    bus.load_start = 1'b0;
    bus.fetch_req = 1'b0;
    @(negedge clk);
    check("fvalid_start", bus.fetch_valid, 0);
    check("count_cleared", 32'(bus.load_count), 0);
    check("ovf_cleared", bus.overflow, 0);
    @(posedge clk); #1;
  endtask

  task automatic send_stream(input int n, input bit with_last, output int t_last);
    int i = 0;
    int budget = 0;
    t_last = 0;
    while (i < n && budget < 40000) begin
      bus.load_valid = ($urandom_range(0, 3) != 0);
      bus.load_byte = bq[i];
      bus.load_last = with_last && (i == n - 1);
      bus.fetch_req = $urandom_range(0, 1);
      bus.fetch_addr = $urandom;
      @(negedge clk);
      if (bus.fetch_req) check("stall_load", bus.stall, 1);
      check("fvalid_load", bus.fetch_valid, 0);
      if (bus.load_valid && bus.load_ready) begin
        t_last = cyc;
        i++;
      end
      @(posedge clk); #1;
      budget++;
    end
    if (i < n) check("send_timeout", i, n);
    bus.load_valid = 1'b0;
    bus.load_last = 1'b0;
    bus.fetch_req = 1'b0;
    bus.fetch_addr = 32'h0;
  endtask

  task automatic run_load(input int n);
    logic [31:0] wq [$];
    logic [31:0] w;
    int nw, nkeep, t_last;
    bit seen;
    nw = (n + 3) / 4;
    nkeep = (nw > DEPTH) ? DEPTH : nw;
    for (int i = 0; i < nkeep; i++) begin
      w = 32'h0;
      for (int b = 0; b < 4; b++)
        if (4 * i + b < n) w = w | (32'(bq[4 * i + b]) << (24 - 8 * b));
      wq.push_back(w);
    end
    push_clear();
    foreach (wq[i]) begin
      exp_wa.push_back(i);
      exp_wd.push_back(wq[i]);
    end
    start_load();
    send_stream(n, 1'b1, t_last);
    seen = 1'b0;
    for (int k = 0; k < 8 && !seen; k++) begin
      @(negedge clk);
      if (bus.load_done) seen = 1'b1;
    end
    check("done_seen", seen, 1);
    check("done_latency", cyc - t_last, 2);
    apply_clear();
    foreach (wq[i]) ref_mem[i] = wq[i];
    bus.fetch_req = 1'b1;
    bus.fetch_addr = 32'h0;
    #1;
    check("stall_in_done", bus.stall, 1);
    @(posedge clk); #1;
    check("stall_back_run", bus.stall, 0);
    check("done_one_cycle", bus.load_done, 0);
    @(posedge clk); #1;
    check("fvalid_after_done", bus.fetch_valid, 1);
    check("finstr_after_done", bus.fetch_instr, ref_fetch(0));
    bus.fetch_req = 1'b0;
    check("load_count", 32'(bus.load_count), nkeep);
    check("overflow", bus.overflow, (nw > DEPTH) ? 1 : 0);
    check("write_total", widx, exp_wa.size());
  endtask

  task automatic fill_random(input int n);
    bq.delete();
    for (int i = 0; i < n; i++) bq.push_back(8'($urandom));
  endtask

  initial begin
    int t_dummy;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[5] = 32'hDEAD_BEEF;
    ref_mem[5] = 32'hDEAD_BEEF;
    bus.fetch_req = 1'b0;
    bus.fetch_addr = 32'h0;
    bus.load_start = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_byte = 8'h0;
    bus.load_last = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_fetch(32'd5, 32'hDEAD_BEEF);
    do_fetch(32'h0000_0400, 32'h0000_0013);
    fetch_burst(30);

    bq = '{8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h10, 8'h00, 8'h93};
    run_load(8);
    do_fetch(32'd0, 32'h0000_0013);
    do_fetch(32'd1, 32'h0010_0093);

    bq = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};
    run_load(6);
    do_fetch(32'd0, 32'hAABB_CCDD);
    do_fetch(32'd1, 32'h1122_0000);
    fetch_burst(20);

    fill_random(5);
    run_load(5);
    fetch_burst(10);
    repeat (3) begin
      int n;
      n = $urandom_range(1, 40);
      fill_random(n);
      run_load(n);
      fetch_burst(20);
    end

    // abort after two bytes of a word: nothing may be written
    push_clear();
    start_load();
    fill_random(4);
    send_stream(2, 1'b0, t_dummy);
    bus.fetch_req = 1'b1;
    @(negedge clk);
    check("stall_abort", bus.stall, 1);
    check("fvalid_abort", bus.fetch_valid, 0);
    @(posedge clk); #1;
    bus.fetch_req = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_vals();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    apply_clear();
    @(negedge clk);
    check("abort_no_write", widx, exp_wa.size());
    @(posedge clk); #1;
    fetch_burst(20);

    fill_random(4100);
    run_load(4100);
    do_fetch(32'd1023, ref_mem[1023]);
    fetch_burst(20);

    fill_random(9);
    run_load(9);
    fetch_burst(10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/imem_loader_ctrl.md
# imem_loader_ctrl

Sequencer that owns the write port of the 1024-word instruction memory and shares its read port with the core's fetch stage. It accepts a byte stream, such as a UART or debug link, packs it big-endian into 32-bit words and writes them from word 0 upward. Fetches stall while a load is in progress. It sits between the fetch stage, the boot/debug byte source and the instruction memory array.

## Interface
- DEPTH, 1024: memory depth in 32-bit words.
- ADDR_W, 10: word-address width; DEPTH == 2**ADDR_W.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- fetch_req  input  1  fetch request from core.
- fetch_addr  input  32  word index (not byte address).
- fetch_valid  output  1  fetch_instr valid this cycle.
- fetch_instr  output  32  fetched instruction.
- stall  output  1  fetch not serviced this cycle.
- load_start  input  1  begin a new program load.
- load_valid  input  1  load_byte valid.
- load_byte  input  8  program byte.
- load_last  input  1  qualifies final byte of stream; sampled with an accepted byte.
- load_ready  output  1  byte accepted when load_valid && load_ready.
- mem_raddr  output  ADDR_W  memory read address.
- mem_rdata  input  32  memory read data (combinational read).
- mem_we  output  1  memory write strobe.
- mem_waddr  output  ADDR_W  write address.
- mem_wdata  output  32  write data.
- load_done  output  1  one-cycle pulse at end of load.
- load_count  output  ADDR_W+1  words written by last/current load.
- overflow  output  1  sticky; bytes dropped beyond DEPTH words.

## Operation
- States: RUN (reset state), CLEAR, LOAD, DONE.
- RUN: mem_raddr = fetch_addr[ADDR_W-1:0]. fetch_req registers the result next cycle: fetch_valid=1; fetch_instr=mem_rdata, or 32'h00000013 (NOP) if fetch_addr[31:ADDR_W]≠0. stall=0.
- load_start in RUN: go to CLEAR (if IMEM_CLEAR_EN) else LOAD. Clear byte lane, load_count and overflow. load_start wins over a same-cycle fetch_req: stall=1, no fetch_valid next cycle. load_start in other states is ignored.
- LOAD: load_ready=1. Accepted bytes fill lanes in order [31:24],[23:16],[15:8],[7:0].
  - 4th byte, or load_last: next cycle mem_we=1, mem_waddr=load_count, mem_wdata=packed word with unfilled low lanes zero; load_count+1.
  - load_last: after that write go to DONE. A load_last on a lane-0 byte writes one word with 3 zero lanes.
- Word capacity: once load_count==DEPTH, bytes are still accepted but dropped, no writes, overflow=1. load_last still ends the load. load_count saturates at DEPTH.
- DONE: load_done=1 for one cycle, then RUN.
- All non-RUN states: stall=1 whenever fetch_req, fetch_valid=0, load_ready=0 except in LOAD.

## Timing
- Reset values: fetch_valid=0, fetch_instr=0, stall=0, load_ready=0, mem_we=0, mem_waddr=0, mem_wdata=0, mem_raddr=0, load_done=0, load_count=0, overflow=0; state RUN.
- Fetch latency: 1 cycle, one fetch per cycle, no bubbles in RUN.
- Write latency: mem_we asserts the cycle after the completing byte is accepted. The fill of the next word proceeds in parallel.
- Last byte accepted at cycle T: write at T+1, load_done at T+2, RUN (fetches serviced) from T+3.
- A fetch issued the cycle before load_start still returns fetch_valid.
- rst_n low mid-load: immediate abort to RUN. A partial word is discarded, no write. load_count=0.

## Configuration
- IMEM_CLEAR_EN defined: CLEAR state writes 32'h0 to words 0..DEPTH-1, one per cycle (mem_we=1, mem_waddr incrementing), load_ready=0, then LOAD. Clearing 1024 words takes 1024 cycles.
- Undefined: no CLEAR state. Words beyond the loaded image keep their previous contents.

## Test plan
- Reset, then fetch_req with fetch_addr=5, mem_rdata=32'hDEADBEEF → next cycle fetch_valid=1, fetch_instr=32'hDEADBEEF, stall=0.
- Load bytes 00 00 00 13 | 00 10 00 93 with load_last on 8th byte → writes addr0=32'h00000013, addr1=32'h00100093, load_count=2, load_done pulse 2 cycles after last byte.
- Load 6 bytes AA BB CC DD 11 22 (last on 22) → addr1=32'h11220000, load_count=2.
- fetch_req during LOAD → stall=1, fetch_valid=0. fetch_addr=32'h400 in RUN → fetch_instr=32'h00000013.
- 4100 bytes streamed → 1025th word dropped, overflow=1, load_count=1024, no write with mem_waddr wrap.
- rst_n low after 2 bytes of a word → no mem_we, outputs at reset values. With IMEM_CLEAR_EN: load_start → 1024 zero writes before load_ready rises.
